multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS processor. Each instruction is sequenced through fetch, decode, execute, memory and write-back over several clocks, and a single ALU, a single memory port and the register file are shared across those steps. The block drives every datapath mux and write enable. It tells the ALU control decoder whether to force an add or to decode opcode/funct. It also handshakes with unified memory through `mem_req`/`mem_ack`.

---
 rtl/mc_pkg.sv | 34 +++
 rtl/mc_opclass.sv | 25 ++
 rtl/multicycle_control.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle MIPS control FSM: states, instruction classes, opcodes, mux encodings.
// MC_ILLEGAL_TRAP_EN adds the TRAP state.
package mc_pkg;

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
      S_MEM_WR, S_WB_R, S_WB_I, S_WB_LD, S_BRANCH, S_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE, C_ITYPE, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
   } opclass_t;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_opclass.sv
// Combinational opcode -> instruction-class decoder; zero latency, no flow control.
module mc_opclass
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   output opclass_t   opclass
);

   always_comb begin
      opclass = C_ILLEGAL;
      if (opcode == OP_RTYPE)
         opclass = C_RTYPE;
      else if (opcode[5:3] == 3'b001)
         opclass = C_ITYPE;
      else if (opcode == OP_LB || opcode == OP_LW)
         opclass = C_LOAD;
      else if (opcode == OP_SB || opcode == OP_SW)
         opclass = C_STORE;
      else if (opcode == OP_REGIMM || opcode[5:2] == 4'b0001)
         opclass = C_BRANCH;
      else if (opcode == OP_J)
         opclass = C_JUMP;
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: 3-5 cycles per instruction plus one per mem_ack wait cycle;
// memory stalls hold state with mem_req/mem_we/i_or_d stable. MC_ILLEGAL_TRAP_EN: illegal opcode traps.
module multicycle_control
   import mc_pkg::*;
#(
   parameter logic [1:0] RESET_VECTOR_SEL = 2'b00
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       alu_op_sel,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       instr_retired
`ifdef MC_ILLEGAL_TRAP_EN
   ,output logic      trap
`endif
);

   state_t   state, state_nxt;
   opclass_t opclass;

   mc_opclass u_opclass (.opcode(opcode), .opclass(opclass));

   // funct is consumed by the ALU control decoder and zero by the PC write gate.
   logic unused_inputs;
   assign unused_inputs = ^{funct, zero};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_RESET;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_RESET:    state_nxt = S_FETCH;
         S_FETCH:    if (mem_ack) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opclass)
               C_RTYPE:          state_nxt = S_EXEC_R;
               C_ITYPE:          state_nxt = S_EXEC_I;
               C_LOAD, C_STORE:  state_nxt = S_MEM_ADDR;
               C_BRANCH:         state_nxt = S_BRANCH;
               C_JUMP:           state_nxt = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
               default:          state_nxt = S_TRAP;
`else
               default:          state_nxt = S_FETCH;
`endif
            endcase
         end
         S_EXEC_R:   state_nxt = S_WB_R;
         S_EXEC_I:   state_nxt = S_WB_I;
         S_MEM_ADDR: state_nxt = (opclass == C_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ack) state_nxt = S_WB_LD;
         S_MEM_WR:   if (mem_ack) state_nxt = S_FETCH;
         S_WB_R, S_WB_I, S_WB_LD, S_BRANCH, S_JUMP:
                     state_nxt = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP:     state_nxt = S_TRAP;
`endif
         default:    state_nxt = S_RESET;
      endcase
   end

   always_comb begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCSRC_ALU;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      alu_op_sel    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      instr_retired = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      trap          = 1'b0;
`endif
      unique case (state)
         S_RESET:    pc_source = RESET_VECTOR_SEL;
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ack;
            pc_write  = mem_ack;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
`ifndef MC_ILLEGAL_TRAP_EN
            // Illegal opcodes retire here as a NOP.
            instr_retired = (opclass == C_ILLEGAL);
`endif
         end
         S_EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_RT;
            alu_op_sel = 1'b1;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            alu_op_sel = 1'b1;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
         end
         S_MEM_WR: begin
            mem_req       = 1'b1;
            mem_we        = 1'b1;
            i_or_d        = 1'b1;
            instr_retired = mem_ack;
         end
         S_WB_R: begin
            reg_write     = 1'b1;
            reg_dst       = 1'b1;
            instr_retired = 1'b1;
         end
         S_WB_I: begin
            reg_write     = 1'b1;
            instr_retired = 1'b1;
         end
         S_WB_LD: begin
            reg_write     = 1'b1;
            mem_to_reg    = 1'b1;
            instr_retired = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_RT;
            alu_op_sel    = 1'b1;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            instr_retired = 1'b1;
         end
         S_JUMP: begin
            pc_write      = 1'b1;
            pc_source     = PCSRC_JUMP;
            instr_retired = 1'b1;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP:     trap = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vector checks against hand-computed values.
module tb_multicycle_control;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode, funct;
   logic       zero, mem_ack;
   logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
   logic [1:0] pc_source, alu_src_b;
   logic       alu_src_a, alu_op_sel, reg_write, reg_dst, mem_to_reg, instr_retired;
`ifdef MC_ILLEGAL_TRAP_EN
   logic       trap;
`endif

   int checks = 0;
   int errors = 0;

   multicycle_control dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op_sel(alu_op_sel), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .instr_retired(instr_retired)
`ifdef MC_ILLEGAL_TRAP_EN
      , .trap(trap)
`endif
   );

   always #5 clk = ~clk;

   logic [16:0] outv;
   assign outv = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                  alu_src_a, alu_src_b, alu_op_sel, reg_write, reg_dst, mem_to_reg, instr_retired};

   function automatic logic [16:0] v(input logic req, we, iord, irw, pcw, pwc,
                                     input logic [1:0] pcs, input logic sa,
                                     input logic [1:0] sb, input logic os, rw, rd, m2r, ret);
      return {req, we, iord, irw, pcw, pwc, pcs, sa, sb, os, rw, rd, m2r, ret};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive mem_ack, check outputs mid-cycle, advance past the next edge.
   task automatic cyc(input string tag, input logic ack, input logic [16:0] exp);
      mem_ack = ack;
      @(negedge clk);
      check(tag, 32'(outv), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse(input string tag);
      reset_n = 1'b0;
      #1;
      check(tag, 32'(outv), 32'd0);
`ifdef MC_ILLEGAL_TRAP_EN
      check({tag, "_trap"}, 32'(trap), 32'd0);
`endif
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   logic [16:0] V_ZERO, V_FETCH_ACK, V_FETCH_WAIT, V_DECODE, V_DECODE_RET, V_EXEC_R, V_EXEC_I;
   logic [16:0] V_MEM_RD, V_MEM_WR, V_MEM_WR_RET, V_WB_R, V_WB_I, V_WB_LD, V_BRANCH, V_JUMP;

   initial begin
      //                 req we io irw pcw pwc pcs  sa sb   os rw rd m2r ret
      V_ZERO       = v(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0);
      V_FETCH_ACK  = v(1, 0, 0, 1, 1, 0, 2'd0, 0, 2'd1, 0, 0, 0, 0, 0);
      V_FETCH_WAIT = v(1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 0, 0, 0, 0, 0);
      V_DECODE     = v(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 0, 0, 0, 0, 0);
      V_DECODE_RET = v(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 0, 0, 0, 0, 1);
      V_EXEC_R     = v(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 1, 0, 0, 0, 0);
      V_EXEC_I     = v(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 1, 0, 0, 0, 0);
      V_MEM_RD     = v(1, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0);
      V_MEM_WR     = v(1, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0);
      V_MEM_WR_RET = v(1, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1);
      V_WB_R       = v(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1, 1, 0, 1);
      V_WB_I       = v(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1, 0, 0, 1);
      V_WB_LD      = v(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1, 0, 1, 1);
      V_BRANCH     = v(0, 0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 1, 0, 0, 0, 1);
      V_JUMP       = v(0, 0, 0, 0, 1, 0, 2'd2, 0, 2'd0, 0, 0, 0, 0, 1);

      reset_n = 1'b0; opcode = 6'b000000; funct = 6'b100000; zero = 1'b1; mem_ack = 1'b0;
      @(negedge clk);
      check("in_reset", 32'(outv), 32'(V_ZERO));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc("reset_state", 1'b1, V_ZERO);   // ack while no request is ignored

      // add
      cyc("add_fetch",  1'b1, V_FETCH_ACK);
      cyc("add_decode", 1'b1, V_DECODE);
      cyc("add_exec",   1'b1, V_EXEC_R);
      cyc("add_wb",     1'b1, V_WB_R);

      // addi back to back
      opcode = 6'b001000;
      cyc("addi_fetch",  1'b1, V_FETCH_ACK);
      cyc("addi_decode", 1'b1, V_DECODE);
      cyc("addi_exec",   1'b1, V_EXEC_I);
      cyc("addi_wb",     1'b1, V_WB_I);

      // lw with two wait cycles in FETCH and MEM_RD: 9 cycles
      opcode = 6'b100011;
      cyc("lw_fetch_w1", 1'b0, V_FETCH_WAIT);
      cyc("lw_fetch_w2", 1'b0, V_FETCH_WAIT);
      cyc("lw_fetch",    1'b1, V_FETCH_ACK);
      cyc("lw_decode",   1'b1, V_DECODE);
      cyc("lw_addr",     1'b1, V_EXEC_I);
      cyc("lw_rd_w1",    1'b0, V_MEM_RD);
      cyc("lw_rd_w2",    1'b0, V_MEM_RD);
      cyc("lw_rd",       1'b1, V_MEM_RD);
      cyc("lw_wb",       1'b1, V_WB_LD);

      // sw with one wait in MEM_WR
      opcode = 6'b101011;
      cyc("sw_fetch",  1'b1, V_FETCH_ACK);
      cyc("sw_decode", 1'b1, V_DECODE);
      cyc("sw_addr",   1'b1, V_EXEC_I);
      cyc("sw_wr_w1",  1'b0, V_MEM_WR);
      cyc("sw_wr",     1'b1, V_MEM_WR_RET);

      // beq then j
      opcode = 6'b000100;
      cyc("beq_fetch",  1'b1, V_FETCH_ACK);
      cyc("beq_decode", 1'b1, V_DECODE);
      cyc("beq_branch", 1'b1, V_BRANCH);
      opcode = 6'b000010;
      cyc("j_fetch",  1'b1, V_FETCH_ACK);
      cyc("j_decode", 1'b1, V_DECODE);
      cyc("j_jump",   1'b1, V_JUMP);

      // bltz (REGIMM)
      opcode = 6'b000001;
      cyc("bltz_fetch",  1'b1, V_FETCH_ACK);
      cyc("bltz_decode", 1'b1, V_DECODE);
      cyc("bltz_branch", 1'b1, V_BRANCH);

      // illegal opcode
      opcode = 6'b111111;
      cyc("ill_fetch", 1'b1, V_FETCH_ACK);
`ifdef MC_ILLEGAL_TRAP_EN
      cyc("ill_decode", 1'b1, V_DECODE);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("trap_outs", 32'(outv), 32'(V_ZERO));
         check("trap_flag", 32'(trap), 32'd1);
         @(posedge clk);
         #1;
      end
`else
      cyc("ill_decode", 1'b1, V_DECODE_RET);
      cyc("ill_refetch", 1'b0, V_FETCH_WAIT);
`endif
      reset_pulse("ill_reset");
      cyc("ill_reset_state", 1'b0, V_ZERO);

      // reset asserted mid-MEM_RD drops mem_req immediately
      opcode = 6'b100000;
      cyc("lb_fetch",  1'b1, V_FETCH_ACK);
      cyc("lb_decode", 1'b1, V_DECODE);
      cyc("lb_addr",   1'b1, V_EXEC_I);
      mem_ack = 1'b0;
      @(negedge clk);
      check("lb_rd_req", 32'(outv), 32'(V_MEM_RD));
      reset_pulse("lb_rd_reset");
      cyc("post_reset_state", 1'b0, V_ZERO);
      cyc("post_reset_fetch", 1'b0, V_FETCH_WAIT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
